// File: rtl/cla_addsub_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with a valid/ready stream interface.
// The whole pipe advances together, or holds when the result at the output is not taken.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NG = WIDTH / GROUP;

    generate
        if (WIDTH % GROUP != 0) begin : g_bad_width
            $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP");
        end
        if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_bad_group
            $error("cla_addsub_pipe: GROUP must be 2, 4 or 8");
        end
        if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
            $error("cla_addsub_pipe: STAGES must be 1..3");
        end
    endgenerate

    logic adv;
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;

    // Operand stage: present only when STAGES >= 2
    logic             op_valid;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_c;
    logic [TAG_W-1:0] op_tag;

    generate
        if (STAGES >= 2) begin : g_op_reg
            always_ff @(posedge clk) begin
                // NOTE: sequential state is written with non-blocking assignments only.
                if (!rst_n)   op_valid <= 1'b0;
                else if (adv) op_valid <= in_valid;
            end
            // NOTE: datapath registers carry no reset; the valid bit alone qualifies them.
            always_ff @(posedge clk) begin
                if (adv) begin
                    op_a   <= a;
                    op_b   <= b_eff;
                    op_c   <= cin_eff;
                    op_tag <= tag;
                end
            end
        end else begin : g_op_comb
            assign op_valid = in_valid;
            assign op_a     = a;
            assign op_b     = b_eff;
            assign op_c     = cin_eff;
            assign op_tag   = tag;
        end
    endgenerate

    logic [WIDTH-1:0] bit_g, bit_p;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      grp_c;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        bit_g = op_a & op_b;
        bit_p = op_a ^ op_b;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        for (int j = 0; j < NG; j++) begin
            logic gg, pp;
            gg = 1'b0;
            pp = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                gg = bit_g[j*GROUP+k] | (bit_p[j*GROUP+k] & gg);
                pp = pp & bit_p[j*GROUP+k];
            end
            grp_g[j] = gg;
            grp_p[j] = pp;
        end
        // Second level: each group carry is a flat sum of generate/propagate products
        grp_c[0] = op_c;
        for (int j = 0; j < NG; j++) begin
            logic acc, prod;
            acc  = 1'b0;
            prod = 1'b1;
            for (int m = j; m >= 0; m--) begin
                acc  = acc | (grp_g[m] & prod);
                prod = prod & grp_p[m];
            end
            grp_c[j+1] = acc | (prod & op_c);
        end
    end

    // Carry stage: present only when STAGES == 3
    logic             cg_valid;
    logic [WIDTH-1:0] cg_g, cg_p;
    logic [NG:0]      cg_c;
    logic [TAG_W-1:0] cg_tag;

    generate
        if (STAGES == 3) begin : g_cg_reg
            always_ff @(posedge clk) begin
                if (!rst_n)   cg_valid <= 1'b0;
                else if (adv) cg_valid <= op_valid;
            end
            always_ff @(posedge clk) begin
                if (adv) begin
                    cg_g   <= bit_g;
                    cg_p   <= bit_p;
                    cg_c   <= grp_c;
                    cg_tag <= op_tag;
                end
            end
        end else begin : g_cg_comb
            assign cg_valid = op_valid;
            assign cg_g     = bit_g;
            assign cg_p     = bit_p;
            assign cg_c     = grp_c;
            assign cg_tag   = op_tag;
        end
    endgenerate

    logic [WIDTH-1:0] bit_c, sum;
    always_comb begin
        bit_c = '0;
        for (int j = 0; j < NG; j++) begin
            logic c;
            c = cg_c[j];
            for (int k = 0; k < GROUP; k++) begin
                bit_c[j*GROUP+k] = c;
                c = cg_g[j*GROUP+k] | (cg_p[j*GROUP+k] & c);
            end
        end
        sum = cg_p ^ bit_c;
    end

    // Result register; data only updates on a valid op so it holds across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= cg_valid;
            if (cg_valid) begin
                s       <= sum;
                c_out   <= cg_c[NG];
                ovf     <= bit_c[WIDTH-1] ^ cg_c[NG];
                zero    <= ~|sum;
                out_tag <= cg_tag;
            end
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench: three adder instances (STAGES/GROUP = 1/2, 2/4, 3/8) share one stimulus
// stream; each keeps its own queue of expected results from an arithmetic reference model.
module tb_cla_addsub_pipe;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, sub, c_in, out_ready;
    logic [31:0] a, b;
    logic [3:0]  tag;

    logic        ir[3], ov[3], co[3], vo[3], zo[3];
    logic [31:0] so[3];
    logic [3:0]  to[3];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_stall[3] = '{-1, -1, -1};
    bit   prev_rst_low = 1'b0;
    bit   stall;
    exp_t sb[3][$];
    exp_t e;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(32), .GROUP(2), .STAGES(1), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .sub(sub), .c_in(c_in), .tag(tag), .out_valid(ov[0]), .out_ready(out_ready),
        .s(so[0]), .c_out(co[0]), .ovf(vo[0]), .zero(zo[0]), .out_tag(to[0]));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .sub(sub), .c_in(c_in), .tag(tag), .out_valid(ov[1]), .out_ready(out_ready),
        .s(so[1]), .c_out(co[1]), .ovf(vo[1]), .zero(zo[1]), .out_tag(to[1]));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(8), .STAGES(3), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .sub(sub), .c_in(c_in), .tag(tag), .out_valid(ov[2]), .out_ready(out_ready),
        .s(so[2]), .c_out(co[2]), .ovf(vo[2]), .zero(zo[2]), .out_tag(to[2]));

    task automatic check(input string name, input int k, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h expected=%0h (cycle %0d)", name, k, got, exp, cyc);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic, overflow from the operand/result sign rule
    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb,
                                   input logic sb_, input logic ci, input logic [3:0] tg,
                                   input int c);
        exp_t        m;
        logic [31:0] be;
        logic [32:0] r;
        be    = sb_ ? ~bb : bb;
        r     = {1'b0, aa} + {1'b0, be} + {32'd0, (sb_ | ci)};
        m.s   = r[31:0];
        m.c   = r[32];
        m.v   = (aa[31] == be[31]) && (r[31] != aa[31]);
        m.z   = (r[31:0] == 32'd0);
        m.tag = tg;
        m.cyc = c;
        return m;
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (prev_rst_low) begin
                check("rst_out_valid", k, 64'(ov[k]), 64'(0));
                check("rst_s",         k, 64'(so[k]), 64'(0));
                check("rst_flags",     k, 64'({co[k], vo[k], zo[k]}), 64'(0));
                check("rst_out_tag",   k, 64'(to[k]), 64'(0));
                check("rst_in_ready",  k, 64'(ir[k]), 64'(1));
            end
            if (!rst_n) begin
                sb[k].delete();
            end else begin
                stall = ov[k] && !out_ready;
                check("in_ready", k, 64'(ir[k]), 64'(!stall));
                if (stall) last_stall[k] = cyc;
                if (ov[k]) begin
                    if (sb[k].size() == 0) begin
                        check("unexpected_out", k, 64'(1), 64'(0));
                    end else begin
                        e = sb[k][0];
                        check("s",       k, 64'(so[k]), 64'(e.s));
                        check("c_out",   k, 64'(co[k]), 64'(e.c));
                        check("ovf",     k, 64'(vo[k]), 64'(e.v));
                        check("zero",    k, 64'(zo[k]), 64'(e.z));
                        check("out_tag", k, 64'(to[k]), 64'(e.tag));
                        if (out_ready) begin
                            if (e.cyc > last_stall[k])
                                check("latency", k, 64'(cyc - e.cyc), 64'(k + 1));
                            void'(sb[k].pop_front());
                        end
                    end
                end
                if (in_valid && ir[k]) sb[k].push_back(model(a, b, sub, c_in, tag, cyc));
            end
        end
        prev_rst_low = !rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                         input logic sb_, input logic ci, input logic [3:0] tg);
        in_valid = v;
        a = aa;
        b = bb;
        sub = sb_;
        c_in = ci;
        tag = tg;
        step();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input logic v);
        drive(v, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        step();
        rst_n = 1'b1;

        // Directed corner vectors, back to back
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1);
        drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 4'h2);
        drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 4'h3);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h4);
        drive(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 4'h5);

        // Eight back-to-back random ops with the sink always ready
        for (int i = 0; i < 8; i++) drive_rand(1'b1);
        for (int i = 0; i < 4; i++) drive_rand(1'b0);

        // Fill the pipe against a stalled sink, hold three cycles, release
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_rand(1'b1);
        for (int i = 0; i < 3; i++) drive_rand(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_rand(1'b0);

        // Reset with two ops in flight
        drive_rand(1'b1);
        drive_rand(1'b1);
        rst_n = 1'b0;
        drive_rand(1'b0);
        rst_n = 1'b1;
        drive_rand(1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drive_rand(1'($urandom_range(0, 3) != 0));
        end

        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
            drive_rand(1'b0);
        end
        check("drain_pending", 0, 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
